// File: rtl/cdb_arbiter.sv
// Purpose: per-FU skid FIFOs feeding a round-robin arbiter that drives N_CDB registered CDB lanes.
// Latency: a result accepted into an empty FIFO is broadcast after the following edge (2 edges total).
// Backpressure: fu_ready drops when a FIFO holds FIFO_DEPTH entries; it depends only on the registered count.
module cdb_arbiter #(
    parameter int N_FU       = 3,
    parameter int N_CDB      = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ROB_DEPTH  = 8,
    parameter int NUM_PREGS  = 64,
    localparam int ROB_ID_W  = $clog2(ROB_DEPTH),
    localparam int PR_W      = $clog2(NUM_PREGS)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               flush,
    input  logic [N_FU-1:0]                    fu_valid,
    output logic [N_FU-1:0]                    fu_ready,
    input  logic [N_FU-1:0][ROB_ID_W-1:0]      fu_rob_id,
    input  logic [N_FU-1:0][PR_W-1:0]          fu_pd,
    input  logic [N_FU-1:0][4:0]               fu_rd,
    input  logic [N_FU-1:0][31:0]              fu_value,
    output logic [N_CDB-1:0]                   cdb_valid,
    output logic [N_CDB-1:0][ROB_ID_W-1:0]     cdb_rob_id,
    output logic [N_CDB-1:0][PR_W-1:0]         cdb_pd,
    output logic [N_CDB-1:0][4:0]              cdb_rd,
    output logic [N_CDB-1:0][31:0]             cdb_value
);

    localparam int FU_W  = (N_FU > 1) ? $clog2(N_FU) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LN_W  = $clog2(N_CDB + 1);

    typedef struct packed {
        logic [ROB_ID_W-1:0] rob_id;
        logic [PR_W-1:0]     pd;
        logic [4:0]          rd;
        logic [31:0]         value;
    } entry_t;

    entry_t           mem      [N_FU][FIFO_DEPTH];
    entry_t           head_dat [N_FU];
    logic [PTR_W-1:0] head     [N_FU];
    logic [PTR_W-1:0] tail     [N_FU];
    logic [CNT_W-1:0] count    [N_FU];

    logic [FU_W-1:0]  rr_ptr;
    logic [FU_W-1:0]  rr_nxt;
    logic [N_FU-1:0]  push;
    logic [N_FU-1:0]  grant;
    logic [N_CDB-1:0] lane_vld;
    logic [FU_W-1:0]  lane_src [N_CDB];
    logic [FU_W:0]    scan;
    logic [LN_W-1:0]  n_grant;

    // Ready comes from the registered count only, so fu_valid never loops back into fu_ready.
    always_comb begin
        for (int i = 0; i < N_FU; i++) begin
            fu_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
            push[i]     = fu_valid[i] && fu_ready[i];
            head_dat[i] = mem[i][head[i]];
        end
    end

    // Scan FIFOs starting at rr_ptr; the k-th non-empty FIFO found goes to lane k until lanes run out.
    always_comb begin
        grant    = '0;
        lane_vld = '0;
        rr_nxt   = rr_ptr;
        n_grant  = '0;
        scan     = '0;
        for (int j = 0; j < N_CDB; j++) begin
            lane_src[j] = '0;
        end
        for (int k = 0; k < N_FU; k++) begin
            scan = {1'b0, rr_ptr} + (FU_W+1)'(k);
            if (scan >= (FU_W+1)'(N_FU)) begin
                scan = scan - (FU_W+1)'(N_FU);
            end
            if ((count[scan[FU_W-1:0]] != '0) && (n_grant < LN_W'(N_CDB))) begin
                grant[scan[FU_W-1:0]] = 1'b1;
                for (int j = 0; j < N_CDB; j++) begin
                    if (n_grant == LN_W'(j)) begin
                        lane_vld[j] = 1'b1;
                        lane_src[j] = scan[FU_W-1:0];
                    end
                end
                // Next scan starts just past the most recently granted FU.
                rr_nxt  = (scan == (FU_W+1)'(N_FU - 1)) ? '0 : FU_W'(scan + 1'b1);
                n_grant = n_grant + 1'b1;
            end
        end
    end

    // FIFO storage; no reset needed because count gates every read.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FU; i++) begin
            if (!rst && !flush && push[i]) begin
                mem[i][tail[i]] <= {fu_rob_id[i], fu_pd[i], fu_rd[i], fu_value[i]};
            end
        end
    end

    // FIFO pointers, round-robin pointer and registered CDB lanes; rst outranks flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_FU; i++) begin
                count[i] <= '0;
                head[i]  <= '0;
                tail[i]  <= '0;
            end
            rr_ptr     <= '0;
            cdb_valid  <= '0;
            cdb_rob_id <= '0;
            cdb_pd     <= '0;
            cdb_rd     <= '0;
            cdb_value  <= '0;
        end else if (flush) begin
            // Squash everything buffered; the arbitration position survives.
            for (int i = 0; i < N_FU; i++) begin
                count[i] <= '0;
                head[i]  <= '0;
                tail[i]  <= '0;
            end
            cdb_valid <= '0;
        end else begin
            for (int i = 0; i < N_FU; i++) begin
                if (push[i]) begin
                    tail[i] <= tail[i] + 1'b1;
                end
                if (grant[i]) begin
                    head[i] <= head[i] + 1'b1;
                end
                if (push[i] && !grant[i]) begin
                    count[i] <= count[i] + 1'b1;
                end else if (!push[i] && grant[i]) begin
                    count[i] <= count[i] - 1'b1;
                end
            end
            rr_ptr    <= rr_nxt;
            cdb_valid <= lane_vld;
            // Idle lanes keep stale data; consumers qualify with cdb_valid.
            for (int j = 0; j < N_CDB; j++) begin
                if (lane_vld[j]) begin
                    cdb_rob_id[j] <= head_dat[lane_src[j]].rob_id;
                    cdb_pd[j]     <= head_dat[lane_src[j]].pd;
                    cdb_rd[j]     <= head_dat[lane_src[j]].rd;
                    cdb_value[j]  <= head_dat[lane_src[j]].value;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus queues per FU feed the ports, accepted results
// are queued as expectations, and a negedge monitor matches every CDB lane against FIFO heads.
module tb_cdb_arbiter;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [2:0]       fu_valid;
    logic [2:0]       fu_ready;
    logic [2:0][2:0]  fu_rob_id;
    logic [2:0][5:0]  fu_pd;
    logic [2:0][4:0]  fu_rd;
    logic [2:0][31:0] fu_value;
    logic [1:0]       cdb_valid;
    logic [1:0][2:0]  cdb_rob_id;
    logic [1:0][5:0]  cdb_pd;
    logic [1:0][4:0]  cdb_rd;
    logic [1:0][31:0] cdb_value;

    cdb_arbiter #(
        .N_FU(3), .N_CDB(2), .FIFO_DEPTH(4), .ROB_DEPTH(8), .NUM_PREGS(64)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_rob_id(fu_rob_id), .fu_pd(fu_pd), .fu_rd(fu_rd), .fu_value(fu_value),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_pd(cdb_pd),
        .cdb_rd(cdb_rd), .cdb_value(cdb_value)
    );

    always #5 clk = ~clk;

    // lat: cycles from presentation to broadcast (0 = any); lane: required lane (-1 = any);
    // drop: accepted but squashed by a later flush, so never expected on the CDB.
    typedef struct {
        logic [2:0]  rob;
        logic [5:0]  pd;
        logic [4:0]  rd;
        logic [31:0] val;
        int          lat;
        int          lane;
        bit          drop;
        int          cyc;
    } item_t;

    item_t stim_q [3][$];
    item_t exp_q  [3][$];
    int    cyc    = 0;
    int    errors = 0;
    int    checks = 0;
    bit    mon_en = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic add(input int fu, input logic [2:0] rob, input logic [5:0] pd,
                       input logic [4:0] rd, input logic [31:0] val,
                       input int lat, input int lane, input bit drop);
        item_t it;
        it.rob = rob; it.pd = pd; it.rd = rd; it.val = val;
        it.lat = lat; it.lane = lane; it.drop = drop; it.cyc = 0;
        stim_q[fu].push_back(it);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // One cycle: after the falling edge set rst/flush and present each FU's head item.
    // fu_ready is stable here, so acceptance at the next rising edge is known now.
    task automatic tick(input bit r, input bit f);
        @(negedge clk);
        rst   = r;
        flush = f;
        for (int i = 0; i < 3; i++) begin
            if (stim_q[i].size() > 0) begin
                item_t it;
                it = stim_q[i][0];
                fu_valid[i]  = 1'b1;
                fu_rob_id[i] = it.rob;
                fu_pd[i]     = it.pd;
                fu_rd[i]     = it.rd;
                fu_value[i]  = it.val;
                if (r || f) begin
                    stim_q[i].delete(0);
                end else if (fu_ready[i]) begin
                    stim_q[i].delete(0);
                    if (!it.drop) begin
                        it.cyc = (it.lat > 0) ? cyc + it.lat : 0;
                        exp_q[i].push_back(it);
                    end
                end
            end else begin
                fu_valid[i]  = 1'b0;
                fu_rob_id[i] = '0;
                fu_pd[i]     = '0;
                fu_rd[i]     = '0;
                fu_value[i]  = '0;
            end
        end
    endtask

    task automatic drain(input string name);
        int n;
        int left;
        n = 0;
        left = 1;
        while (left != 0 && n < 300) begin
            tick(1'b0, 1'b0);
            n++;
            left = stim_q[0].size() + stim_q[1].size() + stim_q[2].size()
                 + exp_q[0].size() + exp_q[1].size() + exp_q[2].size();
        end
        checks++;
        if (left != 0) begin
            errors++;
            $display("FAIL drain_%s: %0d results outstanding, required 0", name, left);
        end
        repeat (2) tick(1'b0, 1'b0);
    endtask

    // Monitor: every valid lane must equal the oldest pending result of some FU.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            for (int j = 0; j < 2; j++) begin
                if (cdb_valid[j] === 1'b1) begin
                    int    hit;
                    item_t e;
                    hit = -1;
                    for (int i = 0; i < 3; i++) begin
                        if (hit < 0 && exp_q[i].size() > 0 &&
                            exp_q[i][0].rob === cdb_rob_id[j] && exp_q[i][0].pd === cdb_pd[j] &&
                            exp_q[i][0].rd === cdb_rd[j] && exp_q[i][0].val === cdb_value[j]) begin
                            hit = i;
                        end
                    end
                    checks++;
                    if (hit < 0) begin
                        errors++;
                        $display("FAIL cdb_lane%0d: got rob=%0d pd=%0d rd=%0d value=%h at cycle %0d, required a pending in-order result",
                                 j, cdb_rob_id[j], cdb_pd[j], cdb_rd[j], cdb_value[j], cyc);
                    end else begin
                        e = exp_q[hit][0];
                        exp_q[hit].delete(0);
                        if ((e.cyc != 0 && e.cyc != cyc) || (e.lane >= 0 && e.lane != j)) begin
                            errors++;
                            $display("FAIL cdb_timing value=%h: got lane %0d cycle %0d, required lane %0d cycle %0d",
                                     e.val, j, cyc, e.lane, e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        fu_valid  = '0;
        fu_rob_id = '0;
        fu_pd     = '0;
        fu_rd     = '0;
        fu_value  = '0;

        // Reset state
        repeat (3) tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("reset_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("reset_fu_ready", 32'(fu_ready), 32'h7);
        chk("reset_cdb_value0", cdb_value[0], 32'h0);
        chk("reset_cdb_fields", 32'({cdb_rob_id, cdb_pd, cdb_rd}), 32'h0);
        mon_en = 1'b1;

        // Single push: 2-edge latency, lane 0 only, then idle
        add(0, 3'd3, 6'd17, 5'd5, 32'hDEADBEEF, 2, 0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("single_no_bypass", 32'(cdb_valid), 32'h0);
        tick(1'b0, 1'b0);
        chk("single_valid", 32'(cdb_valid), 32'h1);
        tick(1'b0, 1'b0);
        chk("single_idle_after", 32'(cdb_valid), 32'h0);

        // Reset again so contention starts at rr_ptr = 0
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);

        // Contention: FU0/FU1 win the first cycle, FU2 follows on lane 0
        add(0, 3'd0, 6'd10, 5'd1, 32'd100, 2, 0, 1'b0);
        add(1, 3'd1, 6'd11, 5'd2, 32'd101, 2, 1, 1'b0);
        add(2, 3'd2, 6'd12, 5'd3, 32'd102, 3, 0, 1'b0);
        drain("contention");

        // Backpressure: all FUs stream; with rr_ptr back at 0 the FIFOs fill as
        // FU2 (after edge 8), FU1 (after edge 9), FU0 (after edge 10).
        for (int k = 0; k < 10; k++) begin
            add(0, 3'(k), 6'(20 + k), 5'd1, 32'h1000 + 32'(k), 0, -1, 1'b0);
            add(1, 3'(k), 6'(30 + k), 5'd2, 32'h2000 + 32'(k), 0, -1, 1'b0);
            add(2, 3'(k), 6'(40 + k), 5'd3, 32'h3000 + 32'(k), 0, -1, 1'b0);
        end
        for (int t = 0; t <= 10; t++) begin
            tick(1'b0, 1'b0);
            if (t == 0) chk("bp_ready_start", 32'(fu_ready), 32'h7);
            if (t == 8) chk("bp_ready_fu2_full", 32'(fu_ready), 32'h3);
            if (t == 9) chk("bp_ready_fu1_full", 32'(fu_ready), 32'h5);
            if (t == 10) chk("bp_ready_fu1_back", 32'(fu_ready), 32'h6);
        end
        drain("backpressure");

        // Wrap-around: FU2 alone, values 0..9 on lane 0 one per cycle
        for (int k = 0; k < 10; k++) begin
            add(2, 3'(k), 6'(k), 5'(k), 32'(k), 2, 0, 1'b0);
        end
        drain("wrap");

        // Single FU0 result leaves rr_ptr = 1 for the flush scenario
        add(0, 3'd7, 6'd63, 5'd31, 32'hCAFE0000, 2, 0, 1'b0);
        drain("rr_set");

        // Flush: B and X broadcast first, then FU0 holds 2 and FU1 holds 1 when flush hits
        add(0, 3'd1, 6'd1, 5'd1, 32'h0000000A, 0, -1, 1'b1);
        add(0, 3'd2, 6'd2, 5'd2, 32'h0000000C, 0, -1, 1'b1);
        add(1, 3'd3, 6'd3, 5'd3, 32'h0000000B, 2, 0, 1'b0);
        add(1, 3'd4, 6'd4, 5'd4, 32'h0000000D, 0, -1, 1'b1);
        add(2, 3'd5, 6'd5, 5'd5, 32'h00000005, 2, 1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        add(2, 3'd6, 6'd6, 5'd6, 32'h0000F0F0, 2, 0, 1'b0);
        tick(1'b0, 1'b1);
        add(1, 3'd0, 6'd9, 5'd9, 32'h00000E0E, 2, 0, 1'b0);
        tick(1'b0, 1'b0);
        chk("flush_cdb_valid", 32'(cdb_valid), 32'h0);
        chk("flush_fu_ready", 32'(fu_ready), 32'h7);
        drain("flush");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
